// File: rtl/cic_int_feeder_if.sv
// Sample/strobe bundle between an upstream source, cic_int_feeder and the CIC interpolator.
// underflow_cnt is present only when CIC_FEED_UFCNT_EN is defined.
interface cic_feed_if #(
   parameter int INPUT_WIDTH = 15,
   parameter int FIFO_DEPTH  = 4
) ();
   localparam int FW = $clog2(FIFO_DEPTH) + 1;

   logic                   en;
   logic                   flush;
   logic                   s_valid;
   logic [INPUT_WIDTH-1:0] s_data;
   logic                   s_ready;
   logic                   nd;
   logic [INPUT_WIDTH-1:0] din;
   logic                   underflow;
   logic [FW-1:0]          fill;
   logic                   running;
`ifdef CIC_FEED_UFCNT_EN
   logic [15:0]            underflow_cnt;

   modport master (output en, flush, s_valid, s_data,
                   input  s_ready, nd, din, underflow, fill, running, underflow_cnt);
   modport slave  (input  en, flush, s_valid, s_data,
                   output s_ready, nd, din, underflow, fill, running, underflow_cnt);
`else
   modport master (output en, flush, s_valid, s_data,
                   input  s_ready, nd, din, underflow, fill, running);
   modport slave  (input  en, flush, s_valid, s_data,
                   output s_ready, nd, din, underflow, fill, running);
`endif
endinterface

// File: rtl/cic_int_feeder.sv
// Buffers upstream samples and feeds the CIC interpolator one sample every INTERPOLATION_RATE clocks.
// Optional saturating underflow counter enabled by defining CIC_FEED_UFCNT_EN.
module cic_int_feeder #(
   parameter int INPUT_WIDTH        = 15,
   parameter int INTERPOLATION_RATE = 8,
   parameter int FIFO_DEPTH         = 4,
   parameter int PRIME_LEVEL        = 2
) (
   input  logic      clk,
   input  logic      rst,
   cic_feed_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = AW + 1;
   localparam int PW = $clog2(INTERPOLATION_RATE);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t                 state_reg;
   logic [PW-1:0]          phase_reg;
   logic [INPUT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_reg;
   logic [AW-1:0]          rd_ptr_reg;
   logic [FW-1:0]          fill_reg;
   logic                   nd_reg;
   logic [INPUT_WIDTH-1:0] din_reg;
   logic                   underflow_reg;
   logic                   running_reg;

   logic                   s_ready;
   logic                   push;
   logic                   pop;
   logic                   strobe;
   logic                   phase_last;
   logic [PW-1:0]          phase_next;

   assign s_ready    = (fill_reg < FW'(FIFO_DEPTH));
   // A flush discards anything offered in the same cycle.
   assign push       = bus.s_valid & s_ready & ~bus.flush;
   assign phase_last = (phase_reg == PW'(INTERPOLATION_RATE - 1));
   assign phase_next = phase_last ? '0 : phase_reg + PW'(1);
   assign strobe     = (state_reg == RUN) & bus.en & phase_last;
   // A strobe coinciding with flush goes out as a zero-stuffed underflow.
   assign pop        = strobe & ~bus.flush & (fill_reg != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= bus.s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         phase_reg     <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         fill_reg      <= '0;
         nd_reg        <= 1'b0;
         din_reg       <= '0;
         underflow_reg <= 1'b0;
         running_reg   <= 1'b0;
      end else begin
         nd_reg        <= strobe;
         underflow_reg <= strobe & ~pop;
         if (strobe) begin
            din_reg <= pop ? mem[rd_ptr_reg] : '0;
         end

         if (bus.flush) begin
            fill_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push) begin
               wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
               rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            fill_reg <= fill_reg + FW'(push) - FW'(pop);
         end

         // Dropping en always wins; FIFO contents are kept for the restart.
         if (!bus.en && state_reg != IDLE) begin
            state_reg   <= IDLE;
            phase_reg   <= '0;
            running_reg <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  phase_reg   <= '0;
                  running_reg <= 1'b0;
                  if (bus.en) begin
                     state_reg <= PRIME;
                  end
               end
               PRIME: begin
                  phase_reg <= '0;
                  if (!bus.flush && fill_reg >= FW'(PRIME_LEVEL)) begin
                     state_reg   <= RUN;
                     running_reg <= 1'b1;
                  end
               end
               RUN: begin
                  if (bus.flush) begin
                     state_reg   <= PRIME;
                     phase_reg   <= '0;
                     running_reg <= 1'b0;
                  end else begin
                     phase_reg <= phase_next;
                  end
               end
               default: begin
                  state_reg   <= IDLE;
                  phase_reg   <= '0;
                  running_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.s_ready   = s_ready;
   assign bus.nd        = nd_reg;
   assign bus.din       = din_reg;
   assign bus.underflow = underflow_reg;
   assign bus.fill      = fill_reg;
   assign bus.running   = running_reg;

`ifdef CIC_FEED_UFCNT_EN
   logic [15:0] underflow_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         underflow_cnt_reg <= '0;
      end else if (strobe && !pop && underflow_cnt_reg != 16'hFFFF) begin
         underflow_cnt_reg <= underflow_cnt_reg + 16'd1;
      end
   end

   assign bus.underflow_cnt = underflow_cnt_reg;
`endif
endmodule
